// File: rtl/apb_arb_pkg.sv
// Shared state encoding and default sizing for the APB request arbiter.
// The optional completion timeout is enabled with APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

   localparam int unsigned NUM_REQ_DEF        = 4;
   localparam int unsigned ADDR_W_DEF         = 9;
   localparam int unsigned DATA_W_DEF         = 8;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: the first valid requester at or after i_ptr,
// wrapping at NUM_REQ, reported as a one-hot grant and a binary index.
module apb_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   int unsigned      w_sum;
   logic [IDX_W-1:0] w_k_idx;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_sum   = 0;
      w_k_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_sum = 32'(i_ptr) + k;
         if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
         end
         w_k_idx = IDX_W'(w_sum);
         if (!o_any && i_valid[w_k_idx]) begin
            o_any            = 1'b1;
            o_idx            = w_k_idx;
            o_grant[w_k_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master between NUM_REQ requesters, one transfer at a time.
// Defining APB_ARB_TIMEOUT_EN adds a completion timeout of TIMEOUT_CYCLES.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_grant,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      transfer,
   output logic                      READ_WRITE,
   output logic [ADDR_W-1:0]         apb_write_paddr,
   output logic [ADDR_W-1:0]         apb_read_paddr,
   output logic [DATA_W-1:0]         apb_write_data,
   input  logic                      PENABLE,
   input  logic                      PREADY,
   input  logic                      PSLVERR,
   input  logic [DATA_W-1:0]         apb_read_data_out
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e              r_state;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    r_owner;
   logic                r_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_transfer;
   logic [NUM_REQ-1:0]  r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic                r_rsp_err;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]    w_idx;
   logic                w_any;
   logic                w_cmpl;
   logic                w_tmo;
   logic                w_out_en;

   apb_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .i_valid (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_cmpl = (r_state == ISSUE) && PENABLE && PREADY;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMO_W-1:0] r_tmo_cnt;

   // Counts ISSUE cycles; held at zero elsewhere so every ISSUE entry starts fresh.
   always_ff @(posedge PCLK) begin
      if (PRESET || (r_state != ISSUE)) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_tmo = (r_state == ISSUE) && !w_cmpl && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^TIMEOUT_CYCLES;
   assign w_tmo        = 1'b0;
`endif

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_transfer  <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_ptr      <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                  r_owner    <= w_idx;
                  r_write    <= req_write[w_idx];
                  r_addr     <= req_addr[32'(w_idx)*ADDR_W +: ADDR_W];
                  r_wdata    <= req_wdata[32'(w_idx)*DATA_W +: DATA_W];
                  r_transfer <= 1'b1;
                  r_state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (w_cmpl || w_tmo) begin
                  r_transfer  <= 1'b0;
                  r_rsp_valid <= NUM_REQ'(1) << r_owner;
                  r_rsp_err   <= w_cmpl ? PSLVERR : 1'b1;
                  r_rsp_rdata <= (w_cmpl && !r_write) ? apb_read_data_out : '0;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               r_rsp_valid <= '0;
               r_rsp_rdata <= '0;
               r_rsp_err   <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Reset forces every output low immediately, including mid-transfer.
   assign w_out_en        = r_transfer && !PRESET;
   assign transfer        = w_out_en;
   assign READ_WRITE      = w_out_en && r_write;
   assign apb_write_paddr = (w_out_en && r_write)  ? r_addr  : '0;
   assign apb_write_data  = (w_out_en && r_write)  ? r_wdata : '0;
   assign apb_read_paddr  = (w_out_en && !r_write) ? r_addr  : '0;
   assign req_grant       = (!PRESET && (r_state == IDLE)) ? w_grant : '0;
   assign rsp_valid       = PRESET ? '0 : r_rsp_valid;
   assign rsp_rdata       = PRESET ? '0 : r_rsp_rdata;
   assign rsp_err         = !PRESET && r_rsp_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: write, read, error, fairness, reset abort,
// and (with APB_ARB_TIMEOUT_EN) the completion timeout.
module tb_apb_req_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned AW = 9;
   localparam int unsigned DW = 8;

   logic            PCLK = 1'b0;
   logic            PRESET;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_write;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [NR-1:0]   req_grant;
   logic [NR-1:0]   rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;
   logic            transfer;
   logic            READ_WRITE;
   logic [AW-1:0]   apb_write_paddr;
   logic [AW-1:0]   apb_read_paddr;
   logic [DW-1:0]   apb_write_data;
   logic            PENABLE;
   logic            PREADY;
   logic            PSLVERR;
   logic [DW-1:0]   apb_read_data_out;

   int n_checks = 0;
   int n_errors = 0;

   apb_req_arbiter #(
      .NUM_REQ        (NR),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .PCLK              (PCLK),
      .PRESET            (PRESET),
      .req_valid         (req_valid),
      .req_write         (req_write),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .req_grant         (req_grant),
      .rsp_valid         (rsp_valid),
      .rsp_rdata         (rsp_rdata),
      .rsp_err           (rsp_err),
      .transfer          (transfer),
      .READ_WRITE        (READ_WRITE),
      .apb_write_paddr   (apb_write_paddr),
      .apb_read_paddr    (apb_read_paddr),
      .apb_write_data    (apb_write_data),
      .PENABLE           (PENABLE),
      .PREADY            (PREADY),
      .PSLVERR           (PSLVERR),
      .apb_read_data_out (apb_read_data_out)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      PRESET            = 1'b1;
      req_valid         = '0;
      req_write         = '0;
      req_addr          = '0;
      req_wdata         = '0;
      PENABLE           = 1'b0;
      PREADY            = 1'b0;
      PSLVERR           = 1'b0;
      apb_read_data_out = '0;
      step();
      step();

      // Reset: everything quiet even with requests pending.
      req_valid = 4'hF;
      #1;
      check("rst_grant", 32'(req_grant), 32'h0);
      check("rst_transfer", 32'(transfer), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      req_valid = '0;
      step();

      // Single write by requester 1.
      PRESET              = 1'b0;
      req_valid           = 4'b0010;
      req_write           = 4'b0010;
      req_addr[1*AW +: AW] = 9'h05A;
      req_wdata[1*DW +: DW] = 8'hC3;
      #1;
      check("wr_grant", 32'(req_grant), 32'h2);
      step();
      req_valid            = '0;
      req_addr[1*AW +: AW] = 9'h111;
      req_wdata[1*DW +: DW] = 8'h00;
      #1;
      check("wr_transfer", 32'(transfer), 32'h1);
      check("wr_rw", 32'(READ_WRITE), 32'h1);
      check("wr_paddr", 32'(apb_write_paddr), 32'h05A);
      check("wr_data", 32'(apb_write_data), 32'hC3);
      check("wr_rpaddr", 32'(apb_read_paddr), 32'h0);
      check("wr_no_grant", 32'(req_grant), 32'h0);
      step();
      PENABLE = 1'b1;
      step();
      check("wr_hold_transfer", 32'(transfer), 32'h1);
      check("wr_hold_paddr", 32'(apb_write_paddr), 32'h05A);
      PREADY            = 1'b1;
      apb_read_data_out = 8'h55;
      step();
      PENABLE = 1'b0;
      PREADY  = 1'b0;
      #1;
      check("wr_rsp_valid", 32'(rsp_valid), 32'h2);
      check("wr_rsp_err", 32'(rsp_err), 32'h0);
      check("wr_rsp_rdata", 32'(rsp_rdata), 32'h0);
      check("wr_resp_transfer", 32'(transfer), 32'h0);
      step();
      check("wr_rsp_one_cycle", 32'(rsp_valid), 32'h0);

      // Completion handshake while idle is ignored.
      PENABLE = 1'b1;
      PREADY  = 1'b1;
      step();
      PENABLE = 1'b0;
      PREADY  = 1'b0;
      check("idle_hs_rsp", 32'(rsp_valid), 32'h0);
      check("idle_hs_rdata", 32'(rsp_rdata), 32'h0);

      // Single read by requester 2 (pointer now at 2).
      req_valid            = 4'b0100;
      req_write            = 4'b0000;
      req_addr[2*AW +: AW] = 9'h1FF;
      #1;
      check("rd_grant", 32'(req_grant), 32'h4);
      step();
      req_valid = '0;
      #1;
      check("rd_rw", 32'(READ_WRITE), 32'h0);
      check("rd_rpaddr", 32'(apb_read_paddr), 32'h1FF);
      check("rd_wpaddr", 32'(apb_write_paddr), 32'h0);
      check("rd_wdata", 32'(apb_write_data), 32'h0);
      step();
      PENABLE           = 1'b1;
      PREADY            = 1'b1;
      apb_read_data_out = 8'h7E;
      step();
      PENABLE           = 1'b0;
      PREADY            = 1'b0;
      apb_read_data_out = 8'h00;
      #1;
      check("rd_rsp_valid", 32'(rsp_valid), 32'h4);
      check("rd_rsp_rdata", 32'(rsp_rdata), 32'h7E);
      check("rd_rsp_err", 32'(rsp_err), 32'h0);
      step();

      // Slave error on a write by requester 3 (pointer now at 3).
      req_valid             = 4'b1000;
      req_write             = 4'b1000;
      req_addr[3*AW +: AW]  = 9'h010;
      req_wdata[3*DW +: DW] = 8'hAA;
      #1;
      check("err_grant", 32'(req_grant), 32'h8);
      step();
      req_valid = '0;
      step();
      PENABLE = 1'b1;
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      step();
      PENABLE = 1'b0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      #1;
      check("err_rsp_valid", 32'(rsp_valid), 32'h8);
      check("err_rsp_err", 32'(rsp_err), 32'h1);
      check("err_rsp_rdata", 32'(rsp_rdata), 32'h0);
      step();

      // Fairness from reset: all four held valid, order 0,1,2,3,0,...
      PRESET = 1'b1;
      step();
      PRESET    = 1'b0;
      req_valid = 4'hF;
      req_write = 4'h0;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("rr_grant_%0d", i), 32'(req_grant), 32'(1) << (i % 4));
         step();
         check($sformatf("rr_issue_grant_%0d", i), 32'(req_grant), 32'h0);
         step();
         PENABLE = 1'b1;
         PREADY  = 1'b1;
         step();
         PENABLE = 1'b0;
         PREADY  = 1'b0;
         #1;
         check($sformatf("rr_rsp_%0d", i), 32'(rsp_valid), 32'(1) << (i % 4));
         check($sformatf("rr_resp_grant_%0d", i), 32'(req_grant), 32'h0);
         step();
      end

      // Reset mid-ISSUE: transfer abandoned, pointer back to 0.
      req_valid = 4'b0100;
      #1;
      check("abort_grant", 32'(req_grant), 32'h4);
      step();
      check("abort_transfer", 32'(transfer), 32'h1);
      PRESET = 1'b1;
      #1;
      check("abort_rst_transfer", 32'(transfer), 32'h0);
      step();
      PRESET    = 1'b0;
      PENABLE   = 1'b1;
      PREADY    = 1'b1;
      req_valid = 4'hF;
      #1;
      check("abort_transfer_after", 32'(transfer), 32'h0);
      check("abort_no_rsp", 32'(rsp_valid), 32'h0);
      check("abort_next_grant", 32'(req_grant), 32'h1);
      step();
      PENABLE   = 1'b0;
      PREADY    = 1'b0;
      req_valid = '0;
      #1;
      check("abort_still_no_rsp", 32'(rsp_valid), 32'h0);
      step();
      PENABLE = 1'b1;
      PREADY  = 1'b1;
      step();
      PENABLE = 1'b0;
      PREADY  = 1'b0;
      check("abort_req0_rsp", 32'(rsp_valid), 32'h1);
      step();

`ifdef APB_ARB_TIMEOUT_EN
      // Timeout: requester 1 read, PREADY never seen; response 8 cycles after entry.
      req_valid = 4'b0010;
      req_write = 4'b0000;
      #1;
      check("tmo_grant", 32'(req_grant), 32'h2);
      step();
      req_valid = '0;
      PENABLE   = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
      end
      check("tmo_not_yet", 32'(rsp_valid), 32'h0);
      step();
      check("tmo_rsp_valid", 32'(rsp_valid), 32'h2);
      check("tmo_rsp_err", 32'(rsp_err), 32'h1);
      check("tmo_rsp_rdata", 32'(rsp_rdata), 32'h0);
      PENABLE = 1'b0;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
